fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the bare PC register → imem → IF/ID path with a PC generator, a single-outstanding request/response port to a variable-latency instruction memory, and a DEPTH-entry prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. An EX-stage redirect flushes everything in flight and restarts fetch at the new target.

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one outstanding imem request, DEPTH-entry prefetch FIFO.
// Latency: request accepted in N, response in N+L, head valid to decode in N+L+1; redirect restarts fetch at R+1.
// Backpressure: id_ready low fills the FIFO; issue stalls while fq_count + outstanding == DEPTH.
//
// Ports: clk/reset_n (async active-low); imem_req_* request port (valid/ready);
//        imem_rsp_* response port; redirect_* EX-stage flush pulse and target;
//        id_* decode handshake with head instr/pc/pc+4; fq_count FIFO occupancy;
//        fetch_fault misaligned-redirect trap flag.
// Build option: define FQ_MISALIGN_TRAP_EN to trap misaligned redirect targets;
//               when undefined the low two target bits are forced to zero.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_req_valid,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_pc_plus_4,
  output logic [$clog2(DEPTH):0]   fq_count,
  output logic                     fetch_fault
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] out_addr;
  logic            out_vld;
  logic            discard;
  logic            fault;
  logic [XLEN-1:0] redir_tgt;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0]   count_n;

  logic            accept, rsp_take, push, pop;
  logic [CW:0]     occ;
  logic            head_from_push;
  logic [XLEN-1:0] nxt_pc;
  logic [31:0]     nxt_instr;

  // Target is always word aligned; a misaligned one is either trapped or silently truncated.
  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FQ_MISALIGN_TRAP_EN
  // Fault latches on a misaligned redirect and is cleared only by an aligned one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            fault <= 1'b0;
    else if (redirect_valid) fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign fault          = 1'b0;
`endif

  assign fetch_fault = fault;

  // A slot is reserved per in-flight request so a response can never hit a full FIFO.
  assign occ            = {1'b0, fq_count} + (CW+1)'(out_vld);
  assign imem_req_valid = reset_n && !redirect_valid && !fault &&
                          (!out_vld || imem_rsp_valid) && (occ < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && out_vld;
  assign push     = rsp_take && !discard && !redirect_valid;
  assign id_valid = (fq_count != '0);
  assign pop      = id_valid && id_ready && !redirect_valid;

  always_comb begin
    count_n        = redirect_valid ? '0 : fq_count + CW'(push) - CW'(pop);
    rd_ptr_n       = redirect_valid ? '0 : rd_ptr + PW'(pop);
    // If the FIFO drains to nothing but a push arrives, the pushed entry is the new head.
    head_from_push = (fq_count == CW'(pop));
    nxt_pc         = head_from_push ? out_addr      : pc_mem[rd_ptr_n];
    nxt_instr      = head_from_push ? imem_rsp_data : instr_mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= out_addr;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc     <= RESET_PC;
      out_vld      <= 1'b0;
      out_addr     <= RESET_PC;
      discard      <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fq_count     <= '0;
      id_instr     <= NOP;
      id_pc        <= '0;
      id_pc_plus_4 <= XLEN'(4);
    end else begin
      if (redirect_valid)  fetch_pc <= redir_tgt;
      else if (accept)     fetch_pc <= fetch_pc + XLEN'(4);

      if (accept) begin
        out_vld  <= 1'b1;
        out_addr <= fetch_pc;
      end else if (rsp_take) begin
        out_vld  <= 1'b0;
      end

      // One stale response is owed at most, since only one request can be in flight.
      if (rsp_take)                          discard <= 1'b0;
      else if (redirect_valid && out_vld)    discard <= 1'b1;

      wr_ptr   <= redirect_valid ? '0 : wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr_n;
      fq_count <= count_n;

      // Head registers hold their last value whenever the FIFO ends up empty.
      if (count_n != '0) begin
        id_pc        <= nxt_pc;
        id_instr     <= nxt_instr;
        id_pc_plus_4 <= nxt_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;
  logic [2:0]  fq_count;
  logic        fetch_fault;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus_4   (id_pc_plus_4),
    .fq_count       (fq_count),
    .fetch_fault    (fetch_fault)
  );

  int          n_assert = 0;
  int          n_fail   = 0;

  // Memory model: fixed latency, returns the request address as the instruction word.
  int          lat      = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  logic        acc_q    = 1'b0;
  logic [31:0] acc_addr_q = '0;

  always @(posedge clk) begin
    acc_q      <= imem_req_valid && imem_req_ready;
    acc_addr_q <= imem_req_addr;
  end

  // One cycle: inputs change on the falling edge, outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if (acc_q) begin
      mem_cnt  = lat;
      mem_addr = acc_addr_q;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr;
      end
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    repeat (5) cyc();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_req_addr",  imem_req_addr, 32'h0);
    chk("rst_id_valid",  32'(id_valid), 0);
    chk("rst_count",     32'(fq_count), 0);
    chk("rst_fault",     32'(fetch_fault), 0);
    chk("rst_instr",     id_instr, 32'h0000_0013);
    chk("rst_pc",        id_pc, 32'h0);
    chk("rst_pc4",       id_pc_plus_4, 32'h4);

    // Streaming, L=1
    cyc(); reset_n = 1'b1; #1;                  // c0
    chk("s0_req_valid", 32'(imem_req_valid), 1);
    chk("s0_req_addr",  imem_req_addr, 32'h0);
    cyc();                                      // c1
    chk("s1_id_valid",  32'(id_valid), 0);
    chk("s1_req_addr",  imem_req_addr, 32'h4);
    chk("s1_req_valid", 32'(imem_req_valid), 1);
    cyc();                                      // c2
    chk("s2_id_valid",  32'(id_valid), 1);
    chk("s2_id_pc",     id_pc, 32'h0);
    chk("s2_id_instr",  id_instr, 32'h0);
    chk("s2_pc4",       id_pc_plus_4, 32'h4);
    chk("s2_count",     32'(fq_count), 1);
    chk("s2_req_addr",  imem_req_addr, 32'h8);
    cyc();                                      // c3
    chk("s3_id_pc",     id_pc, 32'h4);
    chk("s3_id_instr",  id_instr, 32'h4);
    chk("s3_pc4",       id_pc_plus_4, 32'h8);
    cyc();                                      // c4
    chk("s4_id_pc",     id_pc, 32'h8);

    // Backpressure
    id_ready = 1'b0;
    cyc();                                      // c5
    chk("b5_count",     32'(fq_count), 2);
    chk("b5_req_addr",  imem_req_addr, 32'h14);
    chk("b5_req_valid", 32'(imem_req_valid), 1);
    cyc();                                      // c6
    chk("b6_count",     32'(fq_count), 3);
    chk("b6_req_valid", 32'(imem_req_valid), 0);
    cyc();                                      // c7
    chk("b7_count",     32'(fq_count), 4);
    chk("b7_req_valid", 32'(imem_req_valid), 0);
    chk("b7_id_pc",     id_pc, 32'h8);
    id_ready = 1'b1;
    cyc();                                      // c8
    chk("b8_count",     32'(fq_count), 3);
    chk("b8_id_pc",     id_pc, 32'hC);
    chk("b8_req_valid", 32'(imem_req_valid), 1);
    chk("b8_req_addr",  imem_req_addr, 32'h18);
    cyc();                                      // c9
    chk("b9_id_pc",     id_pc, 32'h10);
    cyc();                                      // c10
    chk("b10_id_pc",    id_pc, 32'h14);
    cyc();                                      // c11
    chk("b11_id_pc",    id_pc, 32'h18);
    chk("b11_id_instr", id_instr, 32'h18);

    // Redirect with a request in flight, L=3
    lat = 3;
    do_reset();                                 // c0
    chk("r0_req_addr",  imem_req_addr, 32'h0);
    cyc();                                      // c1
    chk("r1_req_valid", 32'(imem_req_valid), 0);
    do_redirect(32'h100);
    chk("r1_redir_req_valid", 32'(imem_req_valid), 0);
    cyc();                                      // c2
    chk("r2_req_valid", 32'(imem_req_valid), 0);
    chk("r2_count",     32'(fq_count), 0);
    cyc();                                      // c3: stale response returns
    chk("r3_req_valid", 32'(imem_req_valid), 1);
    chk("r3_req_addr",  imem_req_addr, 32'h100);
    cyc();                                      // c4
    chk("r4_id_valid",  32'(id_valid), 0);
    chk("r4_count",     32'(fq_count), 0);
    repeat (3) cyc();                           // c7
    chk("r7_id_valid",  32'(id_valid), 1);
    chk("r7_id_pc",     id_pc, 32'h100);
    chk("r7_id_instr",  id_instr, 32'h100);

    // Redirect coinciding with a response and a pop, L=1
    lat = 1;
    do_reset();                                 // c0
    cyc(); cyc();                               // c2
    chk("x2_id_valid",  32'(id_valid), 1);
    chk("x2_rsp_pending", 32'(imem_req_valid), 1);
    do_redirect(32'h40);
    chk("x2_redir_req_valid", 32'(imem_req_valid), 0);
    cyc();                                      // c3
    chk("x3_count",     32'(fq_count), 0);
    chk("x3_id_valid",  32'(id_valid), 0);
    chk("x3_id_pc_hold", id_pc, 32'h0);
    chk("x3_req_valid", 32'(imem_req_valid), 1);
    chk("x3_req_addr",  imem_req_addr, 32'h40);
    cyc(); cyc();                               // c5
    chk("x5_id_pc",     id_pc, 32'h40);
    chk("x5_count",     32'(fq_count), 1);

    // Misaligned redirect
    do_redirect(32'h102);
    cyc();                                      // c6
    chk("m6_count",     32'(fq_count), 0);
`ifdef FQ_MISALIGN_TRAP_EN
    chk("m6_fault",     32'(fetch_fault), 1);
    chk("m6_req_valid", 32'(imem_req_valid), 0);
`else
    chk("m6_fault",     32'(fetch_fault), 0);
    chk("m6_req_valid", 32'(imem_req_valid), 1);
    chk("m6_req_addr",  imem_req_addr, 32'h100);
`endif
    do_redirect(32'h200);
    cyc();                                      // c7
    chk("m7_fault",     32'(fetch_fault), 0);
    chk("m7_req_valid", 32'(imem_req_valid), 1);
    chk("m7_req_addr",  imem_req_addr, 32'h200);
    cyc(); cyc();                               // c9
    chk("m9_id_pc",     id_pc, 32'h200);

    // Reset mid-operation, L=3, decode stalled
    lat      = 3;
    id_ready = 1'b0;
    do_reset();                                 // c0
    repeat (10) cyc();                          // c10
    chk("q10_count",     32'(fq_count), 3);
    chk("q10_req_valid", 32'(imem_req_valid), 0);
    chk("q10_id_pc",     id_pc, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("q10_rst_id_valid", 32'(id_valid), 0);
    chk("q10_rst_count",    32'(fq_count), 0);
    cyc();                                      // c11
    imem_req_ready = 1'b0;
    reset_n        = 1'b1;
    #1;
    chk("q11_req_valid", 32'(imem_req_valid), 1);
    chk("q11_req_addr",  imem_req_addr, 32'h0);
    cyc();                                      // c12: late response
    cyc();                                      // c13
    chk("q13_count",     32'(fq_count), 0);
    chk("q13_id_valid",  32'(id_valid), 0);
    chk("q13_req_valid", 32'(imem_req_valid), 1);
    chk("q13_req_addr",  imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    repeat (4) cyc();                           // c17
    chk("q17_id_valid",  32'(id_valid), 1);
    chk("q17_id_pc",     id_pc, 32'h0);
    chk("q17_count",     32'(fq_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
